// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 power-up / register-configuration sequencer:
// FSM state encoding, table entry layout, marker entries and small helpers.
package ov7670_cfg_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_RST_HOLD   = 4'd0,
    ST_PWRUP_WAIT = 4'd1,
    ST_FETCH      = 4'd2,
    ST_DECODE     = 4'd3,
    ST_ISSUE      = 4'd4,
    ST_WAIT_RESP  = 4'd5,
    ST_DELAY      = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } cfg_state_e;

  localparam int unsigned REG_AW = 8;
  localparam int unsigned REG_DW = 8;

  // One table entry: SCCB register address and value
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } cfg_entry_t;

  // Marker entries (never valid register writes)
  localparam cfg_entry_t ENTRY_END      = 16'hFFFF;
  localparam cfg_entry_t ENTRY_DELAY    = 16'hFFF0;
  // COM7 software reset, must be the first table entry
  localparam cfg_entry_t ENTRY_COM7_RST = 16'h1280;

  // Largest of three cycle counts, used to size the shared down-counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ov7670_init_rom.sv
// Register table for the OV7670 (QVGA, RGB565). Synchronous read, 1-cycle latency.
// Ports:
//   pclk     - clock
//   reset_n  - async active-low reset (output register reads as END)
//   i_addr   - table index
//   o_entry  - registered {addr, data} entry for i_addr of the previous cycle
module ov7670_init_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned ROM_AW = 8
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic [ROM_AW-1:0] i_addr,
  output cfg_entry_t        o_entry
);

  cfg_entry_t w_entry;
  cfg_entry_t r_entry;

  // Table contents; unused addresses read as END
  always_comb begin
    w_entry = ENTRY_END;
    case (int'(i_addr))
      0:  w_entry = ENTRY_COM7_RST;   // COM7: software reset
      1:  w_entry = ENTRY_DELAY;      // settle after reset
      2:  w_entry = 16'h1214;         // COM7: QVGA, RGB
      3:  w_entry = 16'h40D0;         // COM15: RGB565, full range
      4:  w_entry = 16'h8C00;         // RGB444 off
      5:  w_entry = 16'h1101;         // CLKRC: prescaler
      6:  w_entry = 16'h3A04;         // TSLB
      7:  w_entry = 16'h0C04;         // COM3: DCW enable
      8:  w_entry = 16'h3E19;         // COM14: PCLK divide, manual scaling
      9:  w_entry = 16'h703A;         // SCALING_XSC
      10: w_entry = 16'h7135;         // SCALING_YSC
      11: w_entry = 16'h7211;         // SCALING_DCWCTR
      12: w_entry = 16'h73F1;         // SCALING_PCLK_DIV
      13: w_entry = 16'hA202;         // SCALING_PCLK_DELAY
      14: w_entry = 16'h1716;         // HSTART
      15: w_entry = 16'h1804;         // HSTOP
      16: w_entry = 16'h3224;         // HREF
      17: w_entry = 16'h1902;         // VSTART
      18: w_entry = 16'h1A7A;         // VSTOP
      19: w_entry = 16'h030A;         // VREF
      20: w_entry = 16'h4F80;         // MTX1
      21: w_entry = 16'h5080;         // MTX2
      22: w_entry = 16'h5100;         // MTX3
      23: w_entry = 16'h5222;         // MTX4
      24: w_entry = 16'h535E;         // MTX5
      25: w_entry = 16'h5480;         // MTX6
      26: w_entry = 16'h589E;         // MTXS
      27: w_entry = 16'h13E7;         // COM8: AGC/AWB/AEC on
      28: w_entry = 16'h6F9F;         // AWB control
      29: w_entry = 16'h1500;         // COM10
      30: w_entry = ENTRY_END;
      default: w_entry = ENTRY_END;
    endcase
  end

  // Registered read port
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) r_entry <= ENTRY_END;
    else          r_entry <= w_entry;
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/ov7670_init_seq.sv
// OV7670 power-up and register-configuration sequencer.
// Releases power-down, holds the camera in hardware reset, waits for power-up,
// then walks the register table and issues each write to the SCCB master.
// Ports:
//   pclk, reset_n          - clock, async active-low reset
//   cam_pwdn, cam_reset_n  - camera power-down / hardware reset pins
//   sccb_valid/ready       - write request handshake to the SCCB master
//   sccb_addr, sccb_data   - register address / value, stable while valid
//   sccb_done, sccb_nack   - transaction completion pulse and NACK flag
//   cfg_done, cfg_error    - sticky completion / failure status
//   cfg_index              - current or last table index
module ov7670_init_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned HW_RST_CYCLES = 1_000,
  parameter int unsigned PWRUP_CYCLES  = 100_000,
  parameter int unsigned SWRST_CYCLES  = 25_000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned ROM_AW        = 8
) (
  input  logic              pclk,
  input  logic              reset_n,
  output logic              cam_pwdn,
  output logic              cam_reset_n,
  output logic              sccb_valid,
  input  logic              sccb_ready,
  output logic [REG_AW-1:0] sccb_addr,
  output logic [REG_DW-1:0] sccb_data,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ROM_AW-1:0] cfg_index
);

  localparam int unsigned CNT_MAX = max3(HW_RST_CYCLES, PWRUP_CYCLES, SWRST_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   HW_LOAD    = CNT_W'(HW_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SWRST_LOAD = CNT_W'(SWRST_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [ROM_AW-1:0]  IDX_LAST   = '1;

  cfg_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ROM_AW-1:0]   r_index, w_index_nxt;
  logic [RETRY_W-1:0]  r_retry, w_retry_nxt;
  logic                r_valid, w_valid_nxt;
  logic [REG_AW-1:0]   r_addr, w_addr_nxt;
  logic [REG_DW-1:0]   r_data, w_data_nxt;
  logic                r_cam_pwdn;
  logic                r_cam_reset_n, w_cam_reset_n_nxt;
  logic                r_cfg_done;
  logic                r_cfg_error;
  cfg_entry_t          w_rom_entry;

  ov7670_init_rom #(
    .ROM_AW (ROM_AW)
  ) u_rom (
    .pclk    (pclk),
    .reset_n (reset_n),
    .i_addr  (r_index),
    .o_entry (w_rom_entry)
  );

  // Next-state, counter, retry and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_index_nxt       = r_index;
    w_retry_nxt       = r_retry;
    w_valid_nxt       = 1'b0;
    w_addr_nxt        = r_addr;
    w_data_nxt        = r_data;
    w_cam_reset_n_nxt = r_cam_reset_n;

    case (r_state)
      // Hold count starts once power-down has been released
      ST_RST_HOLD: begin
        if (!r_cam_pwdn) begin
          if (r_cnt == '0) begin
            w_state_nxt       = ST_PWRUP_WAIT;
            w_cnt_nxt         = PWRUP_LOAD;
            w_cam_reset_n_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end

      ST_PWRUP_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_FETCH;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end

      ST_FETCH: w_state_nxt = ST_DECODE;

      ST_DECODE: begin
        if (w_rom_entry == ENTRY_END) begin
          w_state_nxt = ST_DONE;
        end else if (w_rom_entry == ENTRY_DELAY) begin
          w_state_nxt = ST_DELAY;
          w_cnt_nxt   = SWRST_LOAD;
        end else begin
          w_state_nxt = ST_ISSUE;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = w_rom_entry.addr;
          w_data_nxt  = w_rom_entry.data;
        end
      end

      ST_ISSUE: begin
        if (r_valid && sccb_ready) w_state_nxt = ST_WAIT_RESP;
        else                       w_valid_nxt = 1'b1;
      end

      // Done pulses outside this state are ignored
      ST_WAIT_RESP: begin
        if (sccb_done) begin
          if (sccb_nack) begin
            if (r_retry < RETRY_MAX) begin
              w_retry_nxt = r_retry + RETRY_W'(1);
              w_state_nxt = ST_ISSUE;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_ERROR;
            end
          end else begin
            w_retry_nxt = '0;
            w_index_nxt = r_index + ROM_AW'(1);
            // Index wrapping means the table has no END marker
            w_state_nxt = (r_index == IDX_LAST) ? ST_ERROR : ST_FETCH;
          end
        end
      end

      ST_DELAY: begin
        if (r_cnt == '0) begin
          w_index_nxt = r_index + ROM_AW'(1);
          w_state_nxt = (r_index == IDX_LAST) ? ST_ERROR : ST_FETCH;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DONE:  w_state_nxt = ST_DONE;
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_ERROR;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RST_HOLD;
      r_cnt         <= HW_LOAD;
      r_index       <= '0;
      r_retry       <= '0;
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_cam_pwdn    <= 1'b1;
      r_cam_reset_n <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_cfg_error   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_index       <= w_index_nxt;
      r_retry       <= w_retry_nxt;
      r_valid       <= w_valid_nxt;
      r_addr        <= w_addr_nxt;
      r_data        <= w_data_nxt;
      r_cam_pwdn    <= 1'b0;
      r_cam_reset_n <= w_cam_reset_n_nxt;
      // Status lags the terminal state by one cycle
      r_cfg_done    <= (r_state == ST_DONE);
      r_cfg_error   <= (r_state == ST_ERROR);
    end
  end

  assign cam_pwdn    = r_cam_pwdn;
  assign cam_reset_n = r_cam_reset_n;
  assign sccb_valid  = r_valid;
  assign sccb_addr   = r_addr;
  assign sccb_data   = r_data;
  assign cfg_done    = r_cfg_done;
  assign cfg_error   = r_cfg_error;
  assign cfg_index   = r_index;

endmodule

// File: tb/tb_ov7670_init_seq.sv
// Self-checking bench for ov7670_init_seq with a stub SCCB master that answers
// 10 cycles after each accepted request, with programmable NACKs and stall.
module tb_ov7670_init_seq;

  localparam int unsigned HW = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned SW = 5;
  localparam int unsigned MR = 3;
  localparam int unsigned AW = 8;
  localparam int RESP_LAT = 10;
  localparam int END_IDX  = 30;

  logic          pclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sccb_ready = 1'b1;
  logic          sccb_done = 1'b0;
  logic          sccb_nack = 1'b0;
  logic          cam_pwdn, cam_reset_n, sccb_valid, cfg_done, cfg_error;
  logic [7:0]    sccb_addr, sccb_data;
  logic [AW-1:0] cfg_index;

  ov7670_init_seq #(
    .HW_RST_CYCLES (HW),
    .PWRUP_CYCLES  (PW),
    .SWRST_CYCLES  (SW),
    .MAX_RETRY     (MR),
    .ROM_AW        (AW)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .cam_pwdn    (cam_pwdn),
    .cam_reset_n (cam_reset_n),
    .sccb_valid  (sccb_valid),
    .sccb_ready  (sccb_ready),
    .sccb_addr   (sccb_addr),
    .sccb_data   (sccb_data),
    .sccb_done   (sccb_done),
    .sccb_nack   (sccb_nack),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .cfg_index   (cfg_index)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Stub configuration and observation state
  int         nack_limit = 0;
  int         stall_idx = -1;
  int         stall_len = 20;
  bit         busy = 1'b0;
  int         timer = 0;
  bit         cur_is_e3 = 1'b0;
  int         nack_seen = 0;
  int         stall_cnt = 0;
  bit         stall_used = 1'b0;
  int         stall_seen = 0;
  int         stall_changes = 0;
  logic [7:0] stall_a, stall_d;
  logic       prev_valid = 1'b0;
  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int         valid_rise_cyc[$];
  int         done_cyc_q[$];

  // Stub SCCB master, acting on the falling edge
  always @(negedge pclk) begin
    if (!reset_n) begin
      sccb_ready = 1'b1; sccb_done = 1'b0; sccb_nack = 1'b0;
      busy = 1'b0; timer = 0; stall_cnt = 0; prev_valid = 1'b0;
    end else begin
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (busy) begin
        timer--;
        if (timer == 0) begin
          busy = 1'b0;
          sccb_done = 1'b1;
          done_cyc_q.push_back(cyc);
          if (cur_is_e3 && nack_seen < nack_limit) begin
            sccb_nack = 1'b1;
            nack_seen++;
          end
        end
      end
      if (sccb_valid && !prev_valid) valid_rise_cyc.push_back(cyc);
      prev_valid = sccb_valid;
      if (sccb_valid && !stall_used && stall_idx >= 0 && int'(cfg_index) == stall_idx) begin
        stall_used = 1'b1;
        stall_cnt  = stall_len;
        stall_a    = sccb_addr;
        stall_d    = sccb_data;
      end
      if (stall_cnt > 0) begin
        sccb_ready = 1'b0;
        stall_cnt--;
        stall_seen++;
        if (!sccb_valid || sccb_addr != stall_a || sccb_data != stall_d) stall_changes++;
      end else begin
        sccb_ready = 1'b1;
      end
      if (sccb_valid && sccb_ready && !busy) begin
        log_addr.push_back(sccb_addr);
        log_data.push_back(sccb_data);
        busy      = 1'b1;
        timer     = RESP_LAT;
        cur_is_e3 = (sccb_addr == 8'h40 && sccb_data == 8'hD0);
      end
    end
  end

  // Expected register table, written out independently of the ROM
  logic [15:0] tab [31];
  logic [15:0] exp_q[$];

  typedef struct {
    int nack;
    int stall;
    int exp_e3_issues;
    int exp_done;
    int exp_err;
    int exp_index;
  } scen_t;
  scen_t scen [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Write sequence the stub should see for a given NACK count on entry 3
  task automatic build_expected(input int nack);
    int n;
    exp_q.delete();
    for (int i = 0; i < 31; i++) begin
      if (tab[i] == 16'hFFFF) break;
      if (tab[i] == 16'hFFF0) continue;
      n = 1;
      if (i == 3) n = (nack > int'(MR)) ? int'(MR) + 1 : nack + 1;
      for (int k = 0; k < n; k++) exp_q.push_back(tab[i]);
      if (i == 3 && nack > int'(MR)) break;
    end
  endtask

  task automatic start_run(input int nack, input int sidx);
    reset_n = 1'b0;
    nack_limit = nack; stall_idx = sidx;
    nack_seen = 0; stall_used = 1'b0; stall_seen = 0; stall_changes = 0;
    log_addr.delete(); log_data.delete();
    valid_rise_cyc.delete(); done_cyc_q.delete();
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < budget) begin
      @(posedge pclk); #1; n++;
    end
    checks++;
    if (!(cfg_done || cfg_error)) begin
      failures++;
      $display("FAIL %s: no cfg_done/cfg_error after %0d cycles", name, budget);
    end
  endtask

  logic       pw [1:16];
  logic       rn [1:16];
  logic       vl [1:16];
  logic [7:0] ad15, da15;

  initial begin
    int n, e3, vcount, m;
    tab = '{16'h1280, 16'hFFF0, 16'h1214, 16'h40D0, 16'h8C00, 16'h1101, 16'h3A04,
            16'h0C04, 16'h3E19, 16'h703A, 16'h7135, 16'h7211, 16'h73F1, 16'hA202,
            16'h1716, 16'h1804, 16'h3224, 16'h1902, 16'h1A7A, 16'h030A, 16'h4F80,
            16'h5080, 16'h5100, 16'h5222, 16'h535E, 16'h5480, 16'h589E, 16'h13E7,
            16'h6F9F, 16'h1500, 16'hFFFF};
    scen = '{'{0, -1, 1, 1, 0, END_IDX},
             '{2, -1, 3, 1, 0, END_IDX},
             '{4, -1, 4, 0, 1, 3},
             '{3, -1, 4, 1, 0, END_IDX},
             '{0,  2, 1, 1, 0, END_IDX}};

    // Power-up timing and first write, edge k = k-th rising edge after release
    start_run(0, -1);
    #1;
    chk("rst_pwdn", cam_pwdn, 1);
    chk("rst_cam_reset_n", cam_reset_n, 0);
    chk("rst_valid", sccb_valid, 0);
    chk("rst_addr", sccb_addr, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_index", cfg_index, 0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge pclk); #1;
      pw[k] = cam_pwdn; rn[k] = cam_reset_n; vl[k] = sccb_valid;
      if (k == 15) begin ad15 = sccb_addr; da15 = sccb_data; end
    end
    chk("pwdn_edge1", pw[1], 0);
    chk("cam_reset_n_edge4", rn[4], 0);
    chk("cam_reset_n_edge5", rn[5], 1);
    chk("valid_edge14", vl[14], 0);
    chk("valid_edge15", vl[15], 1);
    chk("first_addr", ad15, 8'h12);
    chk("first_data", da15, 8'h80);
    n = 0;
    while ((valid_rise_cyc.size() < 3 || done_cyc_q.size() < 2) && n < 500) begin
      @(posedge pclk); #1; n++;
    end
    chk("gap_samples", int'(valid_rise_cyc.size() >= 3 && done_cyc_q.size() >= 2), 1);
    if (valid_rise_cyc.size() >= 3 && done_cyc_q.size() >= 2) begin
      // FETCH+DECODE of the marker, 5 DELAY cycles, 3-cycle entry overhead
      chk("gap_after_delay", valid_rise_cyc[1] - done_cyc_q[0], 2 + int'(SW) + 3);
      chk("gap_normal", valid_rise_cyc[2] - done_cyc_q[1], 3);
    end

    // Table-driven scenarios: NACK counts on entry 3 and a ready stall on entry 2
    for (int s = 0; s < 5; s++) begin
      build_expected(scen[s].nack);
      start_run(scen[s].nack, scen[s].stall);
      wait_end($sformatf("s%0d_end", s), 3000);
      repeat (2) @(posedge pclk);
      #1;
      chk($sformatf("s%0d_done", s), cfg_done, scen[s].exp_done);
      chk($sformatf("s%0d_error", s), cfg_error, scen[s].exp_err);
      chk($sformatf("s%0d_index", s), cfg_index, scen[s].exp_index);
      chk($sformatf("s%0d_txns", s), log_addr.size(), exp_q.size());
      e3 = 0;
      for (int i = 0; i < log_addr.size(); i++)
        if (log_addr[i] == 8'h40 && log_data[i] == 8'hD0) e3++;
      chk($sformatf("s%0d_e3_issues", s), e3, scen[s].exp_e3_issues);
      m = (log_addr.size() < exp_q.size()) ? log_addr.size() : exp_q.size();
      for (int i = 0; i < m; i++)
        chk($sformatf("s%0d_wr%0d", s, i), {log_addr[i], log_data[i]}, exp_q[i]);
      if (scen[s].exp_err != 0) begin
        vcount = 0;
        repeat (40) begin @(posedge pclk); #1; if (sccb_valid) vcount++; end
        chk($sformatf("s%0d_no_valid_after_error", s), vcount, 0);
        chk($sformatf("s%0d_no_txn_after_error", s), log_addr.size(), exp_q.size());
      end
      if (scen[s].stall >= 0) begin
        chk("stall_cycles", stall_seen, stall_len);
        chk("stall_changes", stall_changes, 0);
        n = 0;
        for (int i = 0; i < log_addr.size(); i++)
          if (log_addr[i] == 8'h12 && log_data[i] == 8'h14) n++;
        chk("stall_one_txn", n, 1);
      end
    end

    // Reset asserted while entry 5 waits for its response
    start_run(0, -1);
    n = 0;
    while (log_addr.size() < 5 && n < 1000) begin @(posedge pclk); #1; n++; end
    chk("midrst_reached_e5", log_addr.size(), 5);
    repeat (3) @(posedge pclk);
    #2;
    chk("midrst_index_before", cfg_index, 5);
    reset_n = 1'b0;
    #1;
    chk("midrst_pwdn", cam_pwdn, 1);
    chk("midrst_cam_reset_n", cam_reset_n, 0);
    chk("midrst_valid", sccb_valid, 0);
    chk("midrst_addr", sccb_addr, 0);
    chk("midrst_data", sccb_data, 0);
    chk("midrst_done", cfg_done, 0);
    chk("midrst_error", cfg_error, 0);
    chk("midrst_index", cfg_index, 0);
    log_addr.delete(); log_data.delete();
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    chk("midrst_cam_reset_n_low", cam_reset_n, 0);
    n = 0;
    while (log_addr.size() < 1 && n < 200) begin @(posedge pclk); #1; n++; end
    chk("midrst_restart_txn", int'(log_addr.size() >= 1), 1);
    if (log_addr.size() >= 1)
      chk("midrst_restart_entry0", {log_addr[0], log_data[0]}, 16'h1280);
    wait_end("midrst_end", 3000);
    repeat (2) @(posedge pclk);
    #1;
    chk("midrst_final_done", cfg_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
